// File: rtl/cpu_mul_pkg.sv
// Shared types and constants for the multiply sequencer.
// Build option: CPU_MUL_SEQ_MULH_EN enables the second cell pass (MULH, MULHSU, MULHU).
package cpu_mul_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned HALF_W   = 16;
    localparam int unsigned ACC_W    = 49;
    localparam int unsigned ACC_HI_W = ACC_W - DATA_W;

    // Request opcode encoding
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_CAP1   = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_CAP2   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Latched request payload
    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } mul_req_t;

endpackage

// File: rtl/cpu_mul_combine.sv
// Combinational partial-product combine for the multiply sequencer.
// Build option: CPU_MUL_SEQ_MULH_EN adds the high-word path and signed correction.
// Ports:
//   p1_i/p2_i/p3_i  cell partials lo*lo, lo*hi, hi*lo
//   acc_o_c         49-bit low-pass accumulation p1 + (p2+p3)<<16
//   acc_hi_i        bits [48:32] of the first-pass accumulation (MULH build)
//   op_i, a_i, b_i  latched opcode and operands (MULH build)
//   hi_o_c          corrected high result word (MULH build)
module cpu_mul_combine
    import cpu_mul_pkg::*;
(
    input  logic [DATA_W-1:0]   p1_i,
    input  logic [DATA_W-1:0]   p2_i,
    input  logic [DATA_W-1:0]   p3_i,
`ifdef CPU_MUL_SEQ_MULH_EN
    input  logic [ACC_HI_W-1:0] acc_hi_i,
    input  logic [1:0]          op_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [DATA_W-1:0]   hi_o_c,
`endif
    output logic [ACC_W-1:0]    acc_o_c
);

    logic [DATA_W:0] mid;

    // Low-pass accumulation, carried wide so nothing is truncated
    always_comb begin
        mid     = {1'b0, p2_i} + {1'b0, p3_i};
        acc_o_c = ACC_W'(p1_i) + (ACC_W'(mid) << HALF_W);
    end

`ifdef CPU_MUL_SEQ_MULH_EN
    logic [DATA_W-1:0] hi_raw;
    logic [DATA_W-1:0] corr_a;
    logic [DATA_W-1:0] corr_b;

    // p1 here is a.hi*b.hi; the low 32 bits of the first pass cannot carry into the high word
    always_comb begin
        hi_raw = DATA_W'(acc_hi_i) + p1_i;
        corr_a = a_i[DATA_W-1] ? b_i : '0;
        corr_b = b_i[DATA_W-1] ? a_i : '0;
        case (op_i)
            OP_MULH:   hi_o_c = hi_raw - corr_a - corr_b;
            OP_MULHSU: hi_o_c = hi_raw - corr_a;
            default:   hi_o_c = hi_raw;
        endcase
    end
`endif

endmodule

// File: rtl/cpu_mul_seq.sv
// Sequencer for the 16x16 three-partial-product multiplier cell.
// Build option: CPU_MUL_SEQ_MULH_EN enables the MULH family (second cell pass);
// without it req_op is ignored and every request returns the low product word.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   req_valid/req_ready/req_op/a/b     request channel
//   resp_valid/resp_ready/resp_result  response channel
//   mul_src1/mul_src2/mul_en           cell operand and product-register enable
//   mul_p1/mul_p2/mul_p3               registered cell partial products
module cpu_mul_seq
    import cpu_mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic [DATA_W-1:0] mul_src1,
    output logic [DATA_W-1:0] mul_src2,
    output logic              mul_en,
    input  logic [DATA_W-1:0] mul_p1,
    input  logic [DATA_W-1:0] mul_p2,
    input  logic [DATA_W-1:0] mul_p3
);

    state_e            state_q,       state_d;
    logic              req_ready_q,   req_ready_d;
    logic              resp_valid_q,  resp_valid_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;
    logic              mul_en_q,      mul_en_d;
    logic [DATA_W-1:0] mul_src1_q,    mul_src1_d;
    logic [DATA_W-1:0] mul_src2_q,    mul_src2_d;
    logic [ACC_W-1:0]  acc_c;

`ifdef CPU_MUL_SEQ_MULH_EN
    mul_req_t            req_q,    req_d;
    logic [ACC_HI_W-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]   hi_c;
`else
    logic unused_bits;
    assign unused_bits = ^{req_op, acc_c[ACC_W-1:DATA_W]};
`endif

    cpu_mul_combine u_combine (
        .p1_i     (mul_p1),
        .p2_i     (mul_p2),
        .p3_i     (mul_p3),
`ifdef CPU_MUL_SEQ_MULH_EN
        .acc_hi_i (acc_hi_q),
        .op_i     (req_q.op),
        .a_i      (req_q.a),
        .b_i      (req_q.b),
        .hi_o_c   (hi_c),
`endif
        .acc_o_c  (acc_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        mul_en_d      = 1'b0;
        mul_src1_d    = mul_src1_q;
        mul_src2_d    = mul_src2_q;
`ifdef CPU_MUL_SEQ_MULH_EN
        req_d         = req_q;
        acc_hi_d      = acc_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d    = ST_ISSUE1;
                    mul_src1_d = req_a;
                    mul_src2_d = req_b;
                    mul_en_d   = 1'b1;
`ifdef CPU_MUL_SEQ_MULH_EN
                    req_d      = '{op: req_op, a: req_a, b: req_b};
`endif
                end
            end
            ST_ISSUE1: state_d = ST_CAP1;
            ST_CAP1: begin
`ifdef CPU_MUL_SEQ_MULH_EN
                if (req_q.op == OP_MUL) begin
                    resp_result_d = acc_c[DATA_W-1:0];
                    resp_valid_d  = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    // Second pass multiplies the high halves only
                    acc_hi_d   = acc_c[ACC_W-1:DATA_W];
                    mul_src1_d = {HALF_W'(0), req_q.a[DATA_W-1:HALF_W]};
                    mul_src2_d = {HALF_W'(0), req_q.b[DATA_W-1:HALF_W]};
                    mul_en_d   = 1'b1;
                    state_d    = ST_ISSUE2;
                end
`else
                resp_result_d = acc_c[DATA_W-1:0];
                resp_valid_d  = 1'b1;
                state_d       = ST_RESP;
`endif
            end
`ifdef CPU_MUL_SEQ_MULH_EN
            ST_ISSUE2: state_d = ST_CAP2;
            ST_CAP2: begin
                resp_result_d = hi_c;
                resp_valid_d  = 1'b1;
                state_d       = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            mul_en_q      <= 1'b0;
            mul_src1_q    <= '0;
            mul_src2_q    <= '0;
`ifdef CPU_MUL_SEQ_MULH_EN
            req_q         <= '0;
            acc_hi_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            mul_en_q      <= mul_en_d;
            mul_src1_q    <= mul_src1_d;
            mul_src2_q    <= mul_src2_d;
`ifdef CPU_MUL_SEQ_MULH_EN
            req_q         <= req_d;
            acc_hi_q      <= acc_hi_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign mul_en      = mul_en_q;
    assign mul_src1    = mul_src1_q;
    assign mul_src2    = mul_src2_q;

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Self-checking bench for cpu_mul_seq with a behavioural multiplier-cell model.
// Follows CPU_MUL_SEQ_MULH_EN to choose expected results and latencies.
module tb_cpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_en;
    logic [31:0] mul_p1;
    logic [31:0] mul_p2;
    logic [31:0] mul_p3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    cpu_mul_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .mul_src1    (mul_src1),
        .mul_src2    (mul_src2),
        .mul_en      (mul_en),
        .mul_p1      (mul_p1),
        .mul_p2      (mul_p2),
        .mul_p3      (mul_p3)
    );

    always #5 clk = ~clk;

    // Multiplier cell: products registered on enabled edges, cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_p1 <= '0;
            mul_p2 <= '0;
            mul_p3 <= '0;
        end else if (mul_en) begin
            mul_p1 <= 32'(mul_src1[15:0])  * 32'(mul_src2[15:0]);
            mul_p2 <= 32'(mul_src1[15:0])  * 32'(mul_src2[31:16]);
            mul_p3 <= 32'(mul_src1[31:16]) * 32'(mul_src2[15:0]);
        end
    end

    // Reference product via 64-bit sign/zero extension
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
`ifdef CPU_MUL_SEQ_MULH_EN
        logic [63:0] xa;
        logic [63:0] xb;
        xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
`else
        p = {32'b0, a} * {32'b0, b};
        return (op == 2'b00 || op != 2'b00) ? p[31:0] : 32'h0;
`endif
    endfunction

    function automatic int ref_lat(input logic [1:0] op);
`ifdef CPU_MUL_SEQ_MULH_EN
        return (op == 2'b00) ? 2 : 4;
`else
        return (op == 2'b00 || op != 2'b00) ? 2 : 0;
`endif
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e.res = 32'h0;
        e.lat = -1;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return e;
    endfunction

    // Present a request, wait for acceptance, and record its expected result
    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input int exp_lat);
        int n = 0;
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout req_ready=%b required=1", req_ready);
            req_valid = 1'b0;
            return;
        end
        e.res = exp_res;
        e.lat = exp_lat;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; counts edges until resp_valid
    task automatic wait_resp(output logic [31:0] res, output int edges, output int en_cnt);
        edges  = 0;
        en_cnt = mul_en ? 1 : 0;
        while (!resp_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (mul_en) en_cnt++;
        end
        if (!resp_valid) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout resp_valid=%b required=1", resp_valid);
        end
        res = resp_result;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (req_ready !== 1'b0)    begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0)   begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_result !== 32'h0) begin failures++; $display("FAIL rst_resp_result got=%h exp=0", resp_result); end
        checks++; if (mul_en !== 1'b0)       begin failures++; $display("FAIL rst_mul_en got=%b exp=0", mul_en); end
        checks++; if ({mul_src1, mul_src2} !== 64'h0) begin failures++; $display("FAIL rst_mul_src got=%h_%h exp=0", mul_src1, mul_src2); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1)    begin failures++; $display("FAIL post_rst_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res;
        int edges;
        int en_cnt;
        exp_t e;
        drive_req(2'b00, 32'd3, 32'd5, 32'd15, 2);
        wait_resp(res, edges, en_cnt);
        e = pop_exp();
        checks++; if (res !== e.res)  begin failures++; $display("FAIL mul3x5_result got=%h exp=%h", res, e.res); end
        checks++; if (edges !== e.lat) begin failures++; $display("FAIL mul3x5_latency got=%0d exp=%0d", edges, e.lat); end
        checks++; if (en_cnt !== 1)   begin failures++; $display("FAIL mul3x5_en_cycles got=%0d exp=1", en_cnt); end
        release_resp();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mul3x5_valid_drop got=%b exp=0", resp_valid); end
        checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL mul3x5_ready_back got=%b exp=1", req_ready); end
    endtask

    logic [1:0]  t_op [5] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10};
    logic [31:0] t_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] t_b  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
`ifdef CPU_MUL_SEQ_MULH_EN
    logic [31:0] t_exp[5] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`else
    logic [31:0] t_exp[5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
`endif

    task automatic test_mulh_family();
        logic [31:0] res;
        int edges;
        int en_cnt;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_req(t_op[i], t_a[i], t_b[i], t_exp[i], ref_lat(t_op[i]));
            wait_resp(res, edges, en_cnt);
            e = pop_exp();
            checks++; if (res !== e.res)   begin failures++; $display("FAIL family%0d_result got=%h exp=%h", i, res, e.res); end
            checks++; if (edges !== e.lat) begin failures++; $display("FAIL family%0d_latency got=%0d exp=%0d", i, edges, e.lat); end
            release_resp();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int edges;
        int en_cnt;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            drive_req(op, a, b, ref_mul(op, a, b), ref_lat(op));
            wait_resp(res, edges, en_cnt);
            e = pop_exp();
            checks++; if (res !== e.res)   begin failures++; $display("FAIL b2b%0d_result op=%0d got=%h exp=%h", i, op, res, e.res); end
            checks++; if (edges !== e.lat) begin failures++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, edges, e.lat); end
            release_resp();
        end
    endtask

    task automatic test_resp_hold();
        logic [31:0] res;
        int edges;
        int en_cnt;
        exp_t e;
        drive_req(2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 2);
        wait_resp(res, edges, en_cnt);
        e = pop_exp();
        checks++; if (res !== e.res) begin failures++; $display("FAIL hold_result got=%h exp=%h", res, e.res); end
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd9;
        req_b     = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1)  begin failures++; $display("FAIL hold%0d_valid got=%b exp=1", i, resp_valid); end
            checks++; if (resp_result !== e.res) begin failures++; $display("FAIL hold%0d_stable got=%h exp=%h", i, resp_result, e.res); end
            checks++; if (req_ready !== 1'b0)   begin failures++; $display("FAIL hold%0d_ready got=%b exp=0", i, req_ready); end
            checks++; if (mul_en !== 1'b0)      begin failures++; $display("FAIL hold%0d_no_accept mul_en=%b exp=0", i, mul_en); end
        end
        release_resp();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL hold_valid_drop got=%b exp=0", resp_valid); end
        checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL hold_ready_back got=%b exp=1", req_ready); end
        e.res = 32'd81;
        e.lat = 2;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mul_en !== 1'b1) begin failures++; $display("FAIL hold_second_accept mul_en=%b exp=1", mul_en); end
        wait_resp(res, edges, en_cnt);
        e = pop_exp();
        checks++; if (res !== e.res)   begin failures++; $display("FAIL hold_second_result got=%h exp=%h", res, e.res); end
        checks++; if (edges !== e.lat) begin failures++; $display("FAIL hold_second_latency got=%0d exp=%0d", edges, e.lat); end
        release_resp();
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int edges;
        int en_cnt;
        exp_t e;
`ifdef CPU_MUL_SEQ_MULH_EN
        drive_req(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 4);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (mul_en !== 1'b1) begin failures++; $display("FAIL mid_in_issue2 mul_en=%b exp=1", mul_en); end
`else
        drive_req(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'b00, 32'h1234_5678, 32'h9ABC_DEF0), 2);
        checks++; if (mul_en !== 1'b1) begin failures++; $display("FAIL mid_in_issue1 mul_en=%b exp=1", mul_en); end
`endif
        #1 reset_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0)    begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0)   begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_result !== 32'h0) begin failures++; $display("FAIL mid_rst_result got=%h exp=0", resp_result); end
        checks++; if (mul_en !== 1'b0)       begin failures++; $display("FAIL mid_rst_mul_en got=%b exp=0", mul_en); end
        checks++; if ({mul_src1, mul_src2} !== 64'h0) begin failures++; $display("FAIL mid_rst_src got=%h_%h exp=0", mul_src1, mul_src2); end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive_req(2'b00, 32'd7, 32'd6, 32'd42, 2);
        wait_resp(res, edges, en_cnt);
        e = pop_exp();
        checks++; if (res !== e.res)   begin failures++; $display("FAIL mid_after_result got=%h exp=%h", res, e.res); end
        checks++; if (edges !== e.lat) begin failures++; $display("FAIL mid_after_latency got=%0d exp=%0d", edges, e.lat); end
        release_resp();
    endtask

`ifndef CPU_MUL_SEQ_MULH_EN
    task automatic test_no_mulh();
        logic [31:0] res;
        int edges;
        int en_cnt;
        exp_t e;
        drive_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
        wait_resp(res, edges, en_cnt);
        e = pop_exp();
        checks++; if (res !== e.res)   begin failures++; $display("FAIL nomulh_result got=%h exp=%h", res, e.res); end
        checks++; if (edges !== e.lat) begin failures++; $display("FAIL nomulh_latency got=%0d exp=%0d", edges, e.lat); end
        release_resp();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 32'h0;
        req_b      = 32'h0;
        resp_ready = 1'b0;
        test_reset();
        test_mul_basic();
        test_mulh_family();
        test_back_to_back();
        test_resp_hold();
        test_reset_mid();
`ifndef CPU_MUL_SEQ_MULH_EN
        test_no_mulh();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
